ultrasonic_detect_sched: RTL and testbench
==========================================

Name: ultrasonic_detect_sched

Overview:
Parametrised burst/listen scheduler and echo classifier for the TUSS ultrasonic front end. It repeats a burst → blanking → listen cycle while the transducer chip reports ready, and qualifies echoes with a minimum-width filter. It counts hits over an N-burst window and drives a detection flag with on/off hysteresis. It also reports the minimum time-of-flight per window and flags bursts that never finish.

Parameters:
CNT_W, 20, cycle timer width; PERIOD_CYC < 2^CNT_W
BLANK_CYC, 17000, cycles after burst start before listening (minimum range)
PERIOD_CYC, 43000, cycles per burst cycle (burst + listen)
BURSTS_PER_WIN, 5, burst cycles per evaluation window (≥1)
ON_THRESH, 4, hits per window to set detect_state
OFF_THRESH, 2, detect_state clears when hits < OFF_THRESH; OFF_THRESH ≤ ON_THRESH
ECHO_MIN_CYC, 4, consecutive synchronised echo-high cycles that qualify a hit (≥1)
BURST_TIMEOUT, 20000, max cycles in BURST waiting for burst_finish
HC_W, $clog2(BURSTS_PER_WIN+1), hit count width

Ports:
gclk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
tuss_ready  in  1  chip configured and ready
burst_finish  in  1  pulse-generator done, 1-cycle pulse
echo_in  in  1  comparator echo output; asynchronous
burst_en  out  1  request burst
burst_rstn  out  1  pulse-generator re-arm, active-low
detect_state  out  1  object-present flag
tof  out  CNT_W  minimum ToF of last window with ≥1 hit
tof_valid  out  1  1-cycle pulse when tof updates
window_done  out  1  1-cycle pulse at window evaluation
hit_count  out  HC_W  hits in last completed window
burst_fault  out  1  sticky burst-timeout flag

Behaviour:
- Reset values: burst_en=0, burst_rstn=1, detect_state=0, tof=0, tof_valid=0, window_done=0, hit_count=0, burst_fault=0, state=IDLE, timer t=0, burst index=0, window hits=0, tof_min=all-ones.
- echo_in passes a 2-flop synchroniser. All echo logic uses the synchronised value. ToF includes this 2-cycle latency uncompensated.
- FSM states: IDLE, BURST, LISTEN.
  - IDLE: burst_en=0. If tuss_ready=1, go to BURST with t:=0.
  - BURST: burst_en=1 registered, so it is high from the first BURST cycle; t increments each cycle.
    - On burst_finish=1: burst_en:=0, go to LISTEN.
    - Otherwise, on t==BURST_TIMEOUT-1: burst_fault:=1 (sticky until rstn), window state cleared, go to IDLE.
    - If burst_finish and the timeout occur in the same cycle, finish wins.
  - LISTEN: t increments. Listen window is active while BLANK_CYC ≤ t ≤ PERIOD_CYC-1.
    - On t==PERIOD_CYC-1, the cycle ends. If burst index == BURSTS_PER_WIN-1, evaluate the window and reset index to 0; otherwise index+1.
    - Then go to BURST with t:=0.
- tuss_ready=0 in any state: go to IDLE next cycle and burst_en:=0. Burst index, window hits and tof_min are cleared; detect_state, tof and hit_count hold.
  - This has priority over window end: no window_done is issued.
- burst_rstn: 0 for exactly the cycle after burst_finish is sampled in BURST, else 1. burst_finish outside BURST is ignored.
- Echo qualification: run counter increments while the synchronised echo=1 and the listen window is active. It clears on echo=0 or when the window is inactive, and saturates at ECHO_MIN_CYC.
  - The run-start t is latched on the first cycle of each run.
  - When the run counter reaches ECHO_MIN_CYC and no hit has been taken yet this cycle: window hits+1 and tof_min := min(tof_min, run-start t).
  - Only one hit is allowed per burst cycle; the per-cycle hit flag clears on entry to BURST.
- Window evaluation (single cycle, registered outputs visible next cycle):
  - window_done=1 and hit_count := hits, including a hit qualifying in the same final cycle.
  - If hits ≥ ON_THRESH: detect_state := 1.
  - Else if hits < OFF_THRESH: detect_state := 0.
  - Otherwise detect_state holds.
  - If hits ≥ 1: tof := tof_min and tof_valid=1.
  - hits and tof_min are then reinitialised.
- Reset mid-operation: all registers return immediately to their reset values.

Test Plan:
Use sim params BLANK_CYC=10, PERIOD_CYC=40, BURSTS_PER_WIN=5, ON_THRESH=4, OFF_THRESH=2, ECHO_MIN_CYC=3, BURST_TIMEOUT=20; burst_finish is issued 5 cycles after burst_en rises.
1. Echo: tuss_ready=1, with a 3-cycle echo pulse at t=15 (synchronised) in all 5 cycles → window_done after cycle 5, hit_count=5, detect_state=1, tof=15, tof_valid pulses once.
2. Hysteresis: after test 1, send 3 windows with 3, 2 and 1 hits → detect_state stays 1, stays 1, then clears to 0 after the 1-hit window; tof_valid pulses for all three windows.
3. Filtering: 2-cycle echo pulses, plus a 5-cycle pulse at t=5–9 inside the blanking time → hit_count=0, no tof_valid, detect_state unchanged.
4. Multiple echoes: echoes at t=25 and t=12 in the same cycle, and t=30 in another cycle → one hit per cycle, tof=12.
5. Timeout: withhold burst_finish → burst_en drops after 20 cycles, burst_fault=1 sticky; the FSM restarts with hits cleared and no window_done.
6. Abort and simultaneous events: drop tuss_ready at burst index 3 → IDLE, burst_en=0, no window_done, detect_state held. Re-raise tuss_ready → a fresh 5-burst window. Then assert rstn=0 mid-LISTEN → all outputs at reset values.

Source files
------------

// File: rtl/ultrasonic_detect_sched.sv
`default_nettype none
// ============================================================================
// Module  : ultrasonic_detect_sched
// Brief   : Burst/blank/listen scheduler and echo classifier for the TUSS
//           ultrasonic front end, with windowed hit counting and hysteresis.
// Rev     : 1.0  initial release
// ============================================================================
module ultrasonic_detect_sched #(
  parameter int CNT_W          = 20,
  parameter int BLANK_CYC      = 17000,
  parameter int PERIOD_CYC     = 43000,
  parameter int BURSTS_PER_WIN = 5,
  parameter int ON_THRESH      = 4,
  parameter int OFF_THRESH     = 2,
  parameter int ECHO_MIN_CYC   = 4,
  parameter int BURST_TIMEOUT  = 20000,
  parameter int HC_W           = $clog2(BURSTS_PER_WIN + 1)
) (
  input  logic             gclk,
  input  logic             rstn,
  input  logic             tuss_ready,
  input  logic             burst_finish,
  input  logic             echo_in,
  output logic             burst_en,
  output logic             burst_rstn,
  output logic             detect_state,
  output logic [CNT_W-1:0] tof,
  output logic             tof_valid,
  output logic             window_done,
  output logic [HC_W-1:0]  hit_count,
  output logic             burst_fault
);

  localparam int RUN_W = $clog2(ECHO_MIN_CYC + 1);

  localparam logic [CNT_W-1:0] c_blank        = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] c_period_last  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(BURST_TIMEOUT - 1);
  localparam logic [RUN_W-1:0] c_run_last     = RUN_W'(ECHO_MIN_CYC - 1);
  localparam logic [RUN_W-1:0] c_run_max      = RUN_W'(ECHO_MIN_CYC);
  localparam logic [HC_W-1:0]  c_idx_last     = HC_W'(BURSTS_PER_WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_LISTEN = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] t_q;
  logic [HC_W-1:0]  idx_q;
  logic [HC_W-1:0]  hits_q;
  logic [CNT_W-1:0] tof_min_q;
  logic             hit_taken_q;
  logic             burst_en_q;
  logic             burst_rstn_q;
  logic             detect_q;
  logic [CNT_W-1:0] tof_q;
  logic             tof_valid_q;
  logic             window_done_q;
  logic [HC_W-1:0]  hit_count_q;
  logic             fault_q;

  logic             echo_meta_q;
  logic             echo_sync_q;
  logic [RUN_W-1:0] run_q;
  logic [CNT_W-1:0] run_start_q;

  logic             listen_act;
  logic             hit_now;
  logic [CNT_W-1:0] run_start_d;
  logic [CNT_W-1:0] tof_min_d;
  logic [HC_W-1:0]  hits_d;

  // A hit taken in the final listen cycle must still reach the window evaluation,
  // so the evaluation consumes these next-state values rather than the registers.
  always_comb begin
    listen_act  = (state_q == S_LISTEN) && (t_q >= c_blank) && (t_q <= c_period_last);
    run_start_d = (run_q == '0) ? t_q : run_start_q;
    hit_now     = echo_sync_q && listen_act && (run_q == c_run_last) && !hit_taken_q;
    hits_d      = hits_q + HC_W'(hit_now);
    tof_min_d   = (hit_now && (run_start_d < tof_min_q)) ? run_start_d : tof_min_q;
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      run_q       <= '0;
      run_start_q <= '0;
    end else begin
      echo_meta_q <= echo_in;
      echo_sync_q <= echo_meta_q;
      if (echo_sync_q && listen_act) begin
        run_start_q <= run_start_d;
        if (run_q != c_run_max) begin
          run_q <= run_q + RUN_W'(1);
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      t_q           <= '0;
      idx_q         <= '0;
      hits_q        <= '0;
      tof_min_q     <= '1;
      hit_taken_q   <= 1'b0;
      burst_en_q    <= 1'b0;
      burst_rstn_q  <= 1'b1;
      detect_q      <= 1'b0;
      tof_q         <= '0;
      tof_valid_q   <= 1'b0;
      window_done_q <= 1'b0;
      hit_count_q   <= '0;
      fault_q       <= 1'b0;
    end else begin
      window_done_q <= 1'b0;
      tof_valid_q   <= 1'b0;
      burst_rstn_q  <= !((state_q == S_BURST) && burst_finish);
      hits_q        <= hits_d;
      tof_min_q     <= tof_min_d;
      hit_taken_q   <= hit_taken_q | hit_now;

      // Losing the chip discards the partial window but keeps the last verdict.
      if (!tuss_ready) begin
        state_q    <= S_IDLE;
        burst_en_q <= 1'b0;
        t_q        <= '0;
        idx_q      <= '0;
        hits_q     <= '0;
        tof_min_q  <= '1;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q     <= S_BURST;
            burst_en_q  <= 1'b1;
            t_q         <= '0;
            hit_taken_q <= 1'b0;
          end
          S_BURST: begin
            t_q <= t_q + CNT_W'(1);
            if (burst_finish) begin
              burst_en_q <= 1'b0;
              state_q    <= S_LISTEN;
            end else if (t_q == c_timeout_last) begin
              fault_q    <= 1'b1;
              burst_en_q <= 1'b0;
              state_q    <= S_IDLE;
              t_q        <= '0;
              idx_q      <= '0;
              hits_q     <= '0;
              tof_min_q  <= '1;
            end
          end
          S_LISTEN: begin
            t_q <= t_q + CNT_W'(1);
            if (t_q == c_period_last) begin
              state_q     <= S_BURST;
              burst_en_q  <= 1'b1;
              t_q         <= '0;
              hit_taken_q <= 1'b0;
              if (idx_q == c_idx_last) begin
                idx_q         <= '0;
                window_done_q <= 1'b1;
                hit_count_q   <= hits_d;
                if (32'(hits_d) >= ON_THRESH) begin
                  detect_q <= 1'b1;
                end else if (32'(hits_d) < OFF_THRESH) begin
                  detect_q <= 1'b0;
                end
                if (hits_d != '0) begin
                  tof_q       <= tof_min_d;
                  tof_valid_q <= 1'b1;
                end
                hits_q    <= '0;
                tof_min_q <= '1;
              end else begin
                idx_q <= idx_q + HC_W'(1);
              end
            end
          end
          default: begin
            state_q    <= S_IDLE;
            burst_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign burst_en     = burst_en_q;
  assign burst_rstn   = burst_rstn_q;
  assign detect_state = detect_q;
  assign tof          = tof_q;
  assign tof_valid    = tof_valid_q;
  assign window_done  = window_done_q;
  assign hit_count    = hit_count_q;
  assign burst_fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_detect_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_ultrasonic_detect_sched
// Brief   : Self-checking bench: table windows, random windows against a
//           run-scanning reference, plus timeout / abort / reset sequences.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ultrasonic_detect_sched;

  localparam int CNT_W = 8;
  localparam int BLANK = 10;
  localparam int PER   = 40;
  localparam int BPW   = 5;
  localparam int ON    = 4;
  localparam int OFF   = 2;
  localparam int EMIN  = 3;
  localparam int TMO   = 20;
  localparam int HC_W  = $clog2(BPW + 1);

  logic gclk = 1'b0;
  logic rstn = 1'b0;
  logic tuss_ready = 1'b0;
  logic burst_finish = 1'b0;
  logic echo_in = 1'b0;
  logic burst_en, burst_rstn, detect_state, tof_valid, window_done, burst_fault;
  logic [CNT_W-1:0] tof;
  logic [HC_W-1:0]  hit_count;

  int n_vec = 0;
  int n_bad = 0;
  bit m_det = 1'b0;
  int m_tof = 0;

  typedef struct {
    logic [BPW-1:0][PER-1:0] maps;   // synchronised echo level per t, per burst
    logic [BPW-1:0][5:0]     fins;   // t at which burst_finish is sampled
    int                      hc;
    bit                      det;
    bit                      tv;
    int                      tof;
  } win_vec_t;

  win_vec_t tbl[8];

  always #5 gclk = ~gclk;

  ultrasonic_detect_sched #(
    .CNT_W(CNT_W), .BLANK_CYC(BLANK), .PERIOD_CYC(PER), .BURSTS_PER_WIN(BPW),
    .ON_THRESH(ON), .OFF_THRESH(OFF), .ECHO_MIN_CYC(EMIN), .BURST_TIMEOUT(TMO)
  ) dut (
    .gclk(gclk), .rstn(rstn), .tuss_ready(tuss_ready), .burst_finish(burst_finish),
    .echo_in(echo_in), .burst_en(burst_en), .burst_rstn(burst_rstn),
    .detect_state(detect_state), .tof(tof), .tof_valid(tof_valid),
    .window_done(window_done), .hit_count(hit_count), .burst_fault(burst_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PER-1:0] pulse(input int s, input int len);
    logic [PER-1:0] r;
    r = '0;
    for (int i = s; i < s + len && i < PER; i++) r[i] = 1'b1;
    return r;
  endfunction

  // First run of EMIN consecutive high samples inside the listening interval.
  function automatic void burst_model(input logic [PER-1:0] m, input int fin_t,
                                      output bit hit, output int start);
    int lo;
    int run;
    lo = (fin_t + 1 > BLANK) ? fin_t + 1 : BLANK;
    run = 0;
    hit = 1'b0;
    start = 0;
    for (int t = lo; t < PER; t++) begin
      if (m[t]) begin
        run++;
        if (run == EMIN && !hit) begin
          hit = 1'b1;
          start = t - EMIN + 1;
        end
      end else begin
        run = 0;
      end
    end
  endfunction

  function automatic win_vec_t blank_win();
    win_vec_t v;
    for (int b = 0; b < BPW; b++) begin
      v.maps[b] = '0;
      v.fins[b] = 6'd4;
    end
    v.hc = 0; v.det = 1'b0; v.tv = 1'b0; v.tof = 0;
    return v;
  endfunction

  function automatic win_vec_t rand_win();
    win_vec_t v;
    int np;
    v = blank_win();
    for (int b = 0; b < BPW; b++) begin
      np = $urandom_range(3, 0);
      for (int p = 0; p < np; p++)
        v.maps[b] = v.maps[b] | pulse($urandom_range(PER - 1, 2), $urandom_range(5, 1));
      v.fins[b] = 6'($urandom_range(TMO - 1, 4));
    end
    return v;
  endfunction

  // Starts at the mid-cycle point of burst t=0; may stop early at stop_t.
  task automatic burst_cycle(input logic [PER-1:0] m, input int fin_t, input int stop_t,
                             input bit mid_win);
    for (int t = 0; t < PER; t++) begin
      if (t == stop_t) return;
      if (t == 0) begin
        chk("burst_en_start", burst_en, 1);
        if (mid_win) chk("window_done_mid", window_done, 0);
      end
      if (t == 1) begin
        chk("window_done_pulse", window_done, 0);
        chk("tof_valid_pulse", tof_valid, 0);
      end
      if (t == fin_t) chk("burst_en_pre_fin", burst_en, 1);
      if (t == fin_t + 1) begin
        chk("burst_en_post_fin", burst_en, 0);
        chk("burst_rstn_low", burst_rstn, 0);
      end
      if (t == fin_t + 2) chk("burst_rstn_rearm", burst_rstn, 1);
      burst_finish = (t == fin_t);
      echo_in = (t + 2 < PER) ? m[t + 2] : 1'b0;
      @(negedge gclk);
    end
    burst_finish = 1'b0;
    echo_in = 1'b0;
  endtask

  task automatic run_window(input win_vec_t v, input bit use_exp, input string tag);
    bit hit;
    int st;
    int hits;
    int tmin;
    int e_hc, e_tof;
    bit e_det, e_tv;
    hits = 0;
    tmin = 1 << CNT_W;
    for (int b = 0; b < BPW; b++) begin
      burst_cycle(v.maps[b], int'(v.fins[b]), PER, b != 0);
      burst_model(v.maps[b], int'(v.fins[b]), hit, st);
      if (hit) begin
        hits++;
        if (st < tmin) tmin = st;
      end
    end
    if (use_exp) begin
      e_hc = v.hc; e_det = v.det; e_tv = v.tv; e_tof = v.tof;
    end else begin
      e_hc  = hits;
      e_tv  = (hits >= 1);
      e_det = (hits >= ON) ? 1'b1 : ((hits < OFF) ? 1'b0 : m_det);
      e_tof = (hits >= 1) ? tmin : m_tof;
    end
    chk($sformatf("%s.window_done", tag), window_done, 1);
    chk($sformatf("%s.hit_count", tag), hit_count, e_hc);
    chk($sformatf("%s.detect_state", tag), detect_state, e_det);
    chk($sformatf("%s.tof_valid", tag), tof_valid, e_tv);
    chk($sformatf("%s.tof", tag), tof, e_tof);
    m_det = e_det;
    m_tof = e_tof;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s.burst_en", tag), burst_en, 0);
    chk($sformatf("%s.burst_rstn", tag), burst_rstn, 1);
    chk($sformatf("%s.detect_state", tag), detect_state, 0);
    chk($sformatf("%s.tof", tag), tof, 0);
    chk($sformatf("%s.tof_valid", tag), tof_valid, 0);
    chk($sformatf("%s.window_done", tag), window_done, 0);
    chk($sformatf("%s.hit_count", tag), hit_count, 0);
    chk($sformatf("%s.burst_fault", tag), burst_fault, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: finished=0, expected 1");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = blank_win();
    for (int b = 0; b < BPW; b++) tbl[0].maps[b] = pulse(15, 3);
    tbl[0].hc = 5; tbl[0].det = 1; tbl[0].tv = 1; tbl[0].tof = 15;
    for (int b = 0; b < 3; b++) tbl[1].maps[b] = pulse(20, 3);
    tbl[1].hc = 3; tbl[1].det = 1; tbl[1].tv = 1; tbl[1].tof = 20;
    tbl[2].maps[0] = pulse(33, 4);
    tbl[2].maps[4] = pulse(37, 3);
    tbl[2].hc = 2; tbl[2].det = 1; tbl[2].tv = 1; tbl[2].tof = 33;
    tbl[3].maps[2] = pulse(11, 5);
    tbl[3].hc = 1; tbl[3].det = 0; tbl[3].tv = 1; tbl[3].tof = 11;
    tbl[4].maps[0] = pulse(5, 5) | pulse(15, 2) | pulse(30, 2);
    tbl[4].maps[1] = pulse(8, 4) | pulse(15, 2);
    for (int b = 2; b < BPW; b++) tbl[4].maps[b] = pulse(20, 2);
    tbl[4].hc = 0; tbl[4].det = 0; tbl[4].tv = 0; tbl[4].tof = 11;
    tbl[5].maps[0] = pulse(25, 3) | pulse(12, 3);
    tbl[5].maps[1] = pulse(30, 3);
    tbl[5].hc = 2; tbl[5].det = 0; tbl[5].tv = 1; tbl[5].tof = 12;
    for (int b = 0; b < 4; b++) tbl[6].maps[b] = pulse(8, 5);
    tbl[6].hc = 4; tbl[6].det = 1; tbl[6].tv = 1; tbl[6].tof = 10;
    tbl[7].maps[0] = pulse(12, 3) | pulse(25, 3);
    tbl[7].fins[0] = 6'd19;
    tbl[7].hc = 1; tbl[7].det = 0; tbl[7].tv = 1; tbl[7].tof = 25;

    repeat (2) @(negedge gclk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge gclk);
    chk("idle_no_ready.burst_en", burst_en, 0);
    tuss_ready = 1'b1;
    @(negedge gclk);
    chk("first_start.window_done", window_done, 0);

    for (int i = 0; i < 8; i++) run_window(tbl[i], 1'b1, $sformatf("table%0d", i));
    chk("no_fault_yet", burst_fault, 0);

    for (int i = 0; i < 4; i++) run_window(rand_win(), 1'b0, $sformatf("rand%0d", i));

    // Timeout: two counted bursts, then a burst whose finish never comes.
    burst_cycle(pulse(15, 3), 4, PER, 1'b0);
    burst_cycle(pulse(16, 3), 4, PER, 1'b1);
    for (int t = 0; t < TMO; t++) begin
      if (t == 0) chk("timeout.window_done_mid", window_done, 0);
      if (t == TMO - 1) begin
        chk("timeout.burst_en_last", burst_en, 1);
        chk("timeout.fault_before", burst_fault, 0);
      end
      burst_finish = 1'b0;
      echo_in = 1'b0;
      @(negedge gclk);
    end
    chk("timeout.burst_en_drop", burst_en, 0);
    chk("timeout.burst_fault", burst_fault, 1);
    chk("timeout.burst_rstn", burst_rstn, 1);
    @(negedge gclk);
    chk("timeout.restart_window_done", window_done, 0);
    run_window(rand_win(), 1'b0, "post_timeout");
    chk("fault_sticky", burst_fault, 1);

    // Abort during the fourth burst of a window, inside BURST.
    for (int b = 0; b < 3; b++) burst_cycle(pulse(20, 3), 4, PER, b != 0);
    burst_cycle(pulse(20, 3), 4, 2, 1'b1);
    tuss_ready = 1'b0;
    echo_in = 1'b0;
    @(negedge gclk);
    chk("abort.burst_en", burst_en, 0);
    for (int k = 0; k < 4; k++) begin
      chk("abort.window_done", window_done, 0);
      chk("abort.idle_burst_en", burst_en, 0);
      chk("abort.detect_held", detect_state, m_det);
      @(negedge gclk);
    end
    tuss_ready = 1'b1;
    @(negedge gclk);
    chk("abort.restart_window_done", window_done, 0);
    run_window(rand_win(), 1'b0, "post_abort");

    // Asynchronous reset in the middle of LISTEN.
    burst_cycle(pulse(15, 3), 4, PER, 1'b0);
    burst_cycle('0, 4, 25, 1'b1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tuss_ready = 1'b0;
    @(negedge gclk);
    rstn = 1'b1;
    @(negedge gclk);
    chk("after_reset.burst_en", burst_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
